// File: rtl/rgb2gray.sv
// RGB565 to 8-bit grayscale converter, 3-stage pipeline with frame tagging.
// Tags sof/eof ride along with each pixel so the Sobel stage sees aligned markers.
module rgb2gray #(
    parameter logic [23:0] PIC_W = 24'd640,
    parameter logic [23:0] PIC_H = 24'd480
) (
    input  logic        tft_clk,
    input  logic        tft_rst,
    input  logic        ip_flag,
    input  logic [15:0] ip_data,
    output logic        op_flag,
    output logic [7:0]  op_data,
    output logic        op_sof,
    output logic        op_eof
);

    logic [23:0] col;
    logic [23:0] row;
    logic        col_last;
    logic        row_last;

    logic        v1, sof1, eof1;
    logic [7:0]  r8, g8, b8;

    logic        v2, sof2, eof2;
    logic [15:0] pr, pg, pb;

    logic [15:0] sum;
    logic [7:0]  gray;

    assign col_last = (col == PIC_W - 24'd1);
    assign row_last = (row == PIC_H - 24'd1);

    always_ff @(posedge tft_clk or posedge tft_rst) begin
        if (tft_rst) begin
            col <= '0;
            row <= '0;
        end else if (ip_flag) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? 24'd0 : row + 24'd1;
            end else begin
                col <= col + 24'd1;
            end
        end
    end

    // S1: replicate MSBs into LSBs so full-scale inputs map to 255
    always_ff @(posedge tft_clk or posedge tft_rst) begin
        if (tft_rst) begin
            v1   <= 1'b0;
            sof1 <= 1'b0;
            eof1 <= 1'b0;
            r8   <= '0;
            g8   <= '0;
            b8   <= '0;
        end else begin
            v1   <= ip_flag;
            sof1 <= ip_flag && (col == 24'd0) && (row == 24'd0);
            eof1 <= ip_flag && col_last && row_last;
            if (ip_flag) begin
                r8 <= {ip_data[15:11], ip_data[15:13]};
                g8 <= {ip_data[10:5], ip_data[10:9]};
                b8 <= {ip_data[4:0], ip_data[4:2]};
            end
        end
    end

    always_ff @(posedge tft_clk or posedge tft_rst) begin
        if (tft_rst) begin
            v2   <= 1'b0;
            sof2 <= 1'b0;
            eof2 <= 1'b0;
            pr   <= '0;
            pg   <= '0;
            pb   <= '0;
        end else begin
            v2   <= v1;
            sof2 <= sof1;
            eof2 <= eof1;
            if (v1) begin
                pr <= 16'(r8) * 16'd77;
                pg <= 16'(g8) * 16'd150;
                pb <= 16'(b8) * 16'd29;
            end
        end
    end

    // Weights sum to 256, so the 16-bit sum never overflows
    assign sum  = pr + pg + pb;
    assign gray = 8'(sum >> 8);

    always_ff @(posedge tft_clk or posedge tft_rst) begin
        if (tft_rst) begin
            op_flag <= 1'b0;
            op_sof  <= 1'b0;
            op_eof  <= 1'b0;
            op_data <= '0;
        end else begin
            op_flag <= v2;
            op_sof  <= sof2;
            op_eof  <= eof2;
            if (v2) begin
                op_data <= gray;
            end
        end
    end

endmodule

// File: tb/tb_rgb2gray.sv
// Randomized bench for rgb2gray against a frame-index reference model.
// A second 1x1 instance shares the inputs to exercise the degenerate frame.
module tb_rgb2gray;

    localparam int FW = 10;
    localparam int FH = 10;
    localparam int FS = FW * FH;

    logic        tft_clk = 1'b0;
    logic        tft_rst = 1'b1;
    logic        ip_flag = 1'b0;
    logic [15:0] ip_data = 16'd0;
    logic        op_flag, op_sof, op_eof;
    logic [7:0]  op_data;
    logic        s1_flag, s1_sof, s1_eof;
    logic [7:0]  s1_data;

    rgb2gray #(.PIC_W(24'd10), .PIC_H(24'd10)) dut (
        .tft_clk (tft_clk),
        .tft_rst (tft_rst),
        .ip_flag (ip_flag),
        .ip_data (ip_data),
        .op_flag (op_flag),
        .op_data (op_data),
        .op_sof  (op_sof),
        .op_eof  (op_eof)
    );

    rgb2gray #(.PIC_W(24'd1), .PIC_H(24'd1)) dut1 (
        .tft_clk (tft_clk),
        .tft_rst (tft_rst),
        .ip_flag (ip_flag),
        .ip_data (ip_data),
        .op_flag (s1_flag),
        .op_data (s1_data),
        .op_sof  (s1_sof),
        .op_eof  (s1_eof)
    );

    always #5 tft_clk = ~tft_clk;

    typedef struct {
        bit         f;
        bit         s;
        bit         e;
        logic [7:0] d;
    } ent_t;

    ent_t        exp_q[$];
    logic [12:0] obs_q[$];
    int          pix_idx;
    logic [7:0]  last_d;
    int          n_cmp;
    int          n_err;
    logic [15:0] frame_px[FS];
    logic [7:0]  frame_out[FS];

    function automatic logic [7:0] gray_ref(input logic [15:0] p);
        int r, g, b, r8, g8, b8, s;
        r  = int'(p[15:11]);
        g  = int'(p[10:5]);
        b  = int'(p[4:0]);
        r8 = r * 8 + r / 4;
        g8 = g * 4 + g / 16;
        b8 = b * 8 + b / 4;
        s  = (77 * r8 + 150 * g8 + 29 * b8) % 65536;
        return 8'(s / 256);
    endfunction

    task automatic tick(input bit f, input logic [15:0] d);
        ent_t e;
        @(posedge tft_clk);
        #1;
        obs_q.push_back({op_flag, op_sof, op_eof, s1_sof, s1_eof, op_data});
        ip_flag = f;
        ip_data = d;
        e.f = f;
        e.d = gray_ref(d);
        e.s = f && (pix_idx % FS == 0);
        e.e = f && (pix_idx % FS == FS - 1);
        if (f) pix_idx++;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge tft_clk);
        tft_rst = 1'b1;
        ip_flag = 1'b0;
        @(negedge tft_clk);
        tft_rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        pix_idx = 0;
        last_d  = 8'd0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({op_flag, op_sof, op_eof, op_data} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_outs: got %h want 0",
                     {op_flag, op_sof, op_eof, op_data});
        end
        @(negedge tft_clk);
        tft_rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        pix_idx = 0;
        last_d  = 8'd0;
        repeat (3) tick(1'b0, 16'd0);
        n_cmp++;
        if ({op_flag, op_data} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_idle: got %h want 0", {op_flag, op_data});
        end
    endtask

    task automatic test_single();
        logic [15:0] px[5];
        logic [7:0]  want[5];
        int          k;
        px   = '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0, 16'h001F};
        want = '{8'd255, 8'd0, 8'd76, 8'd149, 8'd28};
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, px[i]);
            repeat (4) tick(1'b0, 16'h1234);
        end
        k = 0;
        for (int i = 0; i + 3 < obs_q.size(); i++) begin
            if (exp_q[i].f) begin
                n_cmp++;
                if (obs_q[i + 3][12] !== 1'b1 || k > 4 ||
                    obs_q[i + 3][7:0] !== want[k]) begin
                    n_err++;
                    $display("FAIL single[%0d]: got %h want flag=1 data=%0d",
                             k, obs_q[i + 3], want[k % 5]);
                end
                k++;
            end else begin
                n_cmp++;
                if (obs_q[i + 3][12] !== 1'b0) begin
                    n_err++;
                    $display("FAIL single_gap[%0d]: got flag 1 want 0", i);
                end
            end
        end
    endtask

    task automatic test_frame();
        int          pulses, sofs, eofs, sof_at, eof_at;
        ent_t        e;
        logic [12:0] want;
        do_reset();
        for (int i = 0; i < FS; i++) begin
            frame_px[i] = 16'($urandom);
            tick(1'b1, frame_px[i]);
        end
        repeat (4) tick(1'b0, 16'($urandom));
        pulses = 0; sofs = 0; eofs = 0; sof_at = -1; eof_at = -1;
        for (int i = 0; i + 3 < obs_q.size(); i++) begin
            e = exp_q[i];
            if (e.f) last_d = e.d;
            want = {e.f, e.s, e.e, e.f, e.f, last_d};
            n_cmp++;
            if (obs_q[i + 3] !== want) begin
                n_err++;
                $display("FAIL frame[%0d]: got %h want %h", i, obs_q[i + 3], want);
            end
            if (obs_q[i + 3][12]) begin
                if (pulses < FS) frame_out[pulses] = obs_q[i + 3][7:0];
                pulses++;
                if (obs_q[i + 3][11]) begin sofs++; sof_at = pulses; end
                if (obs_q[i + 3][10]) begin eofs++; eof_at = pulses; end
            end
        end
        n_cmp++;
        if (pulses != FS || sofs != 1 || eofs != 1 || sof_at != 1 || eof_at != FS) begin
            n_err++;
            $display("FAIL frame_tags: pulses=%0d sofs=%0d@%0d eofs=%0d@%0d want 100 1@1 1@100",
                     pulses, sofs, sof_at, eofs, eof_at);
        end
    endtask

    task automatic test_bubbles();
        int          n, pulses;
        ent_t        e;
        logic [12:0] want;
        do_reset();
        n = 0;
        for (int c = 0; n < FS; c++) begin
            if (c % 3 == 2) tick(1'b0, 16'($urandom));
            else begin
                tick(1'b1, frame_px[n]);
                n++;
            end
        end
        repeat (4) tick(1'b0, 16'($urandom));
        pulses = 0;
        for (int i = 0; i + 3 < obs_q.size(); i++) begin
            e = exp_q[i];
            if (e.f) last_d = e.d;
            want = {e.f, e.s, e.e, e.f, e.f, last_d};
            n_cmp++;
            if (obs_q[i + 3] !== want) begin
                n_err++;
                $display("FAIL bubble[%0d]: got %h want %h", i, obs_q[i + 3], want);
            end
            if (obs_q[i + 3][12]) begin
                n_cmp++;
                if (pulses >= FS || obs_q[i + 3][7:0] !== frame_out[pulses]) begin
                    n_err++;
                    $display("FAIL bubble_seq[%0d]: got %0d want %0d",
                             pulses, obs_q[i + 3][7:0], frame_out[pulses % FS]);
                end
                pulses++;
            end
        end
        n_cmp++;
        if (pulses != FS) begin
            n_err++;
            $display("FAIL bubble_count: got %0d want %0d", pulses, FS);
        end
    endtask

    task automatic test_back_to_back();
        int          pulses;
        bit          sof_ok;
        ent_t        e;
        logic [12:0] want;
        do_reset();
        for (int i = 0; i < 2 * FS; i++) tick(1'b1, 16'($urandom));
        repeat (4) tick(1'b0, 16'd0);
        pulses = 0;
        sof_ok = 1'b1;
        for (int i = 0; i + 3 < obs_q.size(); i++) begin
            e = exp_q[i];
            if (e.f) last_d = e.d;
            want = {e.f, e.s, e.e, e.f, e.f, last_d};
            n_cmp++;
            if (obs_q[i + 3] !== want) begin
                n_err++;
                $display("FAIL b2b[%0d]: got %h want %h", i, obs_q[i + 3], want);
            end
            if (obs_q[i + 3][12]) begin
                pulses++;
                if (obs_q[i + 3][11] !== (pulses == 1 || pulses == FS + 1)) sof_ok = 1'b0;
                if (obs_q[i + 3][10] !== (pulses == FS || pulses == 2 * FS)) sof_ok = 1'b0;
            end
        end
        n_cmp++;
        if (!sof_ok || pulses != 2 * FS) begin
            n_err++;
            $display("FAIL b2b_tags: pulses=%0d tags_ok=%0d want 200 1", pulses, sof_ok);
        end
    endtask

    task automatic test_mid_reset();
        ent_t        e;
        logic [12:0] want;
        int          pulses;
        do_reset();
        for (int i = 0; i < 37; i++) tick(1'b1, 16'($urandom));
        tick(1'b1, 16'hFFFF);
        for (int i = 0; i + 3 < obs_q.size(); i++) begin
            e = exp_q[i];
            if (e.f) last_d = e.d;
            want = {e.f, e.s, e.e, e.f, e.f, last_d};
            n_cmp++;
            if (obs_q[i + 3] !== want) begin
                n_err++;
                $display("FAIL pre_rst[%0d]: got %h want %h", i, obs_q[i + 3], want);
            end
        end
        @(posedge tft_clk);
        #3;
        tft_rst = 1'b1;
        ip_flag = 1'b1;
        ip_data = 16'hFFFF;
        #1;
        n_cmp++;
        if ({op_flag, op_sof, op_eof, op_data} !== 11'd0) begin
            n_err++;
            $display("FAIL async_rst: got %h want 0", {op_flag, op_sof, op_eof, op_data});
        end
        repeat (2) begin
            @(posedge tft_clk);
            #1;
            n_cmp++;
            if ({op_flag, op_sof, op_eof, op_data} !== 11'd0) begin
                n_err++;
                $display("FAIL in_rst: got %h want 0", {op_flag, op_sof, op_eof, op_data});
            end
        end
        @(negedge tft_clk);
        tft_rst = 1'b0;
        ip_flag = 1'b0;
        exp_q.delete();
        obs_q.delete();
        pix_idx = 0;
        last_d  = 8'd0;
        for (int i = 0; i < 5; i++) tick(1'b1, 16'($urandom));
        repeat (4) tick(1'b0, 16'd0);
        pulses = 0;
        for (int i = 0; i + 3 < obs_q.size(); i++) begin
            e = exp_q[i];
            if (e.f) last_d = e.d;
            want = {e.f, e.s, e.e, e.f, e.f, last_d};
            n_cmp++;
            if (obs_q[i + 3] !== want) begin
                n_err++;
                $display("FAIL post_rst[%0d]: got %h want %h", i, obs_q[i + 3], want);
            end
            if (obs_q[i + 3][12]) pulses++;
        end
        n_cmp++;
        if (pulses != 5) begin
            n_err++;
            $display("FAIL post_rst_count: got %0d want 5", pulses);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        pix_idx = 0;
        last_d  = 8'd0;
        test_reset();
        test_single();
        test_frame();
        test_bubbles();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
